// File: rtl/serial_link_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : serial_link_scheduler
// Brief   : Round-robin scheduler (urgent override) for one shared serial
//           status transmitter, with frame timing and idle refresh.
// Revision: 1.0
// ============================================================================
module serial_link_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int REFRESH_CYCLES = 1000,
  parameter int URGENT_EN      = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         ack,
  output logic                       tx_init,
  output logic [DATA_W-1:0]          tx_state,
  output logic                       busy,
  output logic                       frame_done,
  output logic [$clog2(NUM_REQ)-1:0] last_src
);

  localparam int PW      = $clog2(NUM_REQ);
  localparam int CNT_MAX = (DATA_W > GAP_CYCLES) ? DATA_W : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int RW      = (REFRESH_CYCLES < 1) ? 1 : $clog2(REFRESH_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_SEND  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [RW-1:0]       rcnt_q, rcnt_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                tx_init_q, tx_init_d;
  logic [DATA_W-1:0]   tx_state_q, tx_state_d;
  logic                busy_q, busy_d;
  logic                frame_done_q, frame_done_d;
  logic [PW-1:0]       last_src_q, last_src_d;

  logic [PW:0]         rr_sum;
  logic [PW-1:0]       rr_cand;
  logic [PW-1:0]       rr_idx;
  logic [PW-1:0]       grant_idx;
  logic                refresh_fire;

  // Scan downward so the last hit is the nearest request at/after the pointer.
  always_comb begin
    rr_sum  = '0;
    rr_cand = '0;
    rr_idx  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      rr_sum = {1'b0, ptr_q} + (PW+1)'(k);
      if (rr_sum >= (PW+1)'(NUM_REQ)) begin
        rr_sum = rr_sum - (PW+1)'(NUM_REQ);
      end
      rr_cand = rr_sum[PW-1:0];
      if (req[rr_cand]) begin
        rr_idx = rr_cand;
      end
    end
    grant_idx    = ((URGENT_EN != 0) && req[0]) ? '0 : rr_idx;
    refresh_fire = (REFRESH_CYCLES != 0) && (int'(rcnt_q) == REFRESH_CYCLES - 1);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    rcnt_d     = rcnt_q;
    ack_d      = '0;
    tx_state_d = tx_state_q;
    last_src_d = last_src_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d            = S_START;
          tx_state_d         = req_data[grant_idx*DATA_W +: DATA_W];
          last_src_d         = grant_idx;
          ptr_d              = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
          ack_d[grant_idx]   = 1'b1;
          rcnt_d             = '0;
        end else if (refresh_fire) begin
          // Refresh re-sends the held word and source; pointer stays put.
          state_d = S_START;
          rcnt_d  = '0;
        end else if (rcnt_q != '1) begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      S_START: begin
        state_d = S_SEND;
        cnt_d   = CW'(DATA_W);
      end
      S_SEND: begin
        if (cnt_q == CW'(1)) begin
          state_d = S_GAP;
          cnt_d   = CW'(GAP_CYCLES);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    tx_init_d    = (state_q == S_START);
    busy_d       = (state_d != S_IDLE);
    frame_done_d = (state_d == S_GAP) && (cnt_d == CW'(1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      ptr_q        <= '0;
      rcnt_q       <= '0;
      ack_q        <= '0;
      tx_init_q    <= 1'b0;
      tx_state_q   <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      last_src_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      rcnt_q       <= rcnt_d;
      ack_q        <= ack_d;
      tx_init_q    <= tx_init_d;
      tx_state_q   <= tx_state_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      last_src_q   <= last_src_d;
    end
  end

  assign ack        = ack_q;
  assign tx_init    = tx_init_q;
  assign tx_state   = tx_state_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign last_src   = last_src_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_link_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_serial_link_scheduler
// Brief   : Directed self-checking bench for serial_link_scheduler.
// Revision: 1.0
// ============================================================================
module tb_serial_link_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] req_data;
  logic [3:0]  ack;
  logic        tx_init;
  logic [3:0]  tx_state;
  logic        busy;
  logic        frame_done;
  logic [1:0]  last_src;

  int checks   = 0;
  int failures = 0;

  serial_link_scheduler #(
    .NUM_REQ(4), .DATA_W(4), .GAP_CYCLES(2), .REFRESH_CYCLES(20), .URGENT_EN(1)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack),
    .tx_init(tx_init), .tx_state(tx_state), .busy(busy),
    .frame_done(frame_done), .last_src(last_src)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset;
    req   = 4'b0000;
    reset = 1'b1;
    tick;
    reset = 1'b0;
  endtask

  // Entered in an IDLE cycle T; returns in the IDLE cycle T+8.
  task automatic do_frame(input string tag, input logic [3:0] req_v,
                          input logic [3:0] req_after, input logic [3:0] gap_pulse,
                          input logic [3:0] exp_ack, input logic [1:0] exp_src,
                          input logic [3:0] exp_data);
    req = req_v;
    tick;
    chk({tag, " ack@T+1"}, ack, exp_ack);
    chk({tag, " busy@T+1"}, busy, 1);
    chk({tag, " tx_init@T+1"}, tx_init, 0);
    chk({tag, " tx_state"}, tx_state, exp_data);
    chk({tag, " last_src"}, last_src, exp_src);
    req = req_after;
    tick;
    chk({tag, " tx_init@T+2"}, tx_init, 1);
    chk({tag, " ack@T+2"}, ack, 0);
    repeat (4) tick;
    chk({tag, " tx_state stable"}, tx_state, exp_data);
    chk({tag, " frame_done@T+6"}, frame_done, 0);
    req = req_after | gap_pulse;
    tick;
    chk({tag, " frame_done@T+7"}, frame_done, 1);
    chk({tag, " busy@T+7"}, busy, 1);
    req = req_after;
    tick;
    chk({tag, " busy@T+8"}, busy, 0);
    chk({tag, " frame_done@T+8"}, frame_done, 0);
  endtask

  initial begin
    int  n;
    logic seen_ack;
    logic seen_busy;

    reset    = 1'b1;
    req      = 4'b0000;
    req_data = 16'h5A93;   // src3=5 src2=A src1=9 src0=3
    tick;
    tick;
    chk("rst ack", ack, 0);
    chk("rst tx_init", tx_init, 0);
    chk("rst busy", busy, 0);
    chk("rst frame_done", frame_done, 0);
    chk("rst tx_state", tx_state, 0);
    chk("rst last_src", last_src, 0);
    reset = 1'b0;
    tick;

    // Test 1: reset while a frame is in SEND.
    req = 4'b0010;
    tick;
    chk("t1a ack", ack, 4'b0010);
    req = 4'b0000;
    tick;
    chk("t1a tx_init", tx_init, 1);
    tick;
    chk("t1a busy mid-send", busy, 1);
    reset = 1'b1;
    #2;
    chk("t1 async busy", busy, 0);
    chk("t1 async tx_state", tx_state, 0);
    chk("t1 async last_src", last_src, 0);
    tick;
    chk("t1 held ack", ack, 0);
    chk("t1 held tx_init", tx_init, 0);
    reset = 1'b0;
    do_frame("t1b", 4'b0100, 4'b0000, 4'b0000, 4'b0100, 2'd2, 4'hA);

    // Test 2: round-robin among 1..3 with request held.
    pulse_reset;
    do_frame("t2 f0", 4'b1110, 4'b1110, 4'b0000, 4'b0010, 2'd1, 4'h9);
    do_frame("t2 f1", 4'b1110, 4'b1110, 4'b0000, 4'b0100, 2'd2, 4'hA);
    do_frame("t2 f2", 4'b1110, 4'b1110, 4'b0000, 4'b1000, 2'd3, 4'h5);
    do_frame("t2 f3", 4'b1110, 4'b0000, 4'b0000, 4'b0010, 2'd1, 4'h9);

    // Test 3: urgent source 0 wins, then RR resumes at pointer 1.
    pulse_reset;
    do_frame("t3 u0", 4'b1111, 4'b1111, 4'b0000, 4'b0001, 2'd0, 4'h3);
    do_frame("t3 u1", 4'b1111, 4'b1111, 4'b0000, 4'b0001, 2'd0, 4'h3);
    do_frame("t3 u2", 4'b1111, 4'b1111, 4'b0000, 4'b0001, 2'd0, 4'h3);
    do_frame("t3 rr1", 4'b1110, 4'b1110, 4'b0000, 4'b0010, 2'd1, 4'h9);
    do_frame("t3 rr2", 4'b1110, 4'b0000, 4'b0000, 4'b0100, 2'd2, 4'hA);

    // Test 4: refresh after 20 idle cycles. Counter is 0 on IDLE entry E,
    // fires at count 19 (E+19), START at E+20, tx_init at E+21.
    pulse_reset;
    do_frame("t4", 4'b1000, 4'b0000, 4'b0000, 4'b1000, 2'd3, 4'h5);
    n        = 0;
    seen_ack = 1'b0;
    while (tx_init !== 1'b1 && n < 40) begin
      tick;
      n++;
      if (ack !== 4'b0000) seen_ack = 1'b1;
    end
    chk("t4 refresh latency", n, 21);
    chk("t4 refresh no ack", seen_ack, 0);
    chk("t4 refresh tx_state", tx_state, 4'h5);
    chk("t4 refresh last_src", last_src, 2'd3);
    chk("t4 refresh busy", busy, 1);
    repeat (6) tick;
    chk("t4 refresh ends", busy, 0);

    // Test 5: request on the refresh-fire cycle wins; GAP pulse is ignored.
    repeat (19) tick;
    chk("t5 idle before fire", busy, 0);
    do_frame("t5", 4'b0010, 4'b0000, 4'b0100, 4'b0010, 2'd1, 4'h9);
    seen_ack  = 1'b0;
    seen_busy = 1'b0;
    repeat (12) begin
      tick;
      if (ack !== 4'b0000) seen_ack = 1'b1;
      if (busy !== 1'b0) seen_busy = 1'b1;
    end
    chk("t5 gap pulse no ack", seen_ack, 0);
    chk("t5 gap pulse no frame", seen_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
